// File: rtl/dec_pkg.sv
// ---------------------------------------------------------------------------
// dec_pkg : mode codes and skid-buffer state encoding for mirror_decoder_skid
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dec_pkg;

  localparam logic [1:0] MODE_ONEHOT = 2'd0;
  localparam logic [1:0] MODE_MIRROR = 2'd1;
  localparam logic [1:0] MODE_THERMO = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/mirror_decode_core.sv
// ---------------------------------------------------------------------------
// mirror_decode_core : combinational one-hot / mirror-pair / thermometer decode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mirror_decode_core
  import dec_pkg::*;
#(
  parameter int IN_W = 4
) (
  input  logic [IN_W-1:0]      din,
  input  logic [1:0]           mode,
  output logic [(2**IN_W)-1:0] dout,
  output logic                 err
);

  localparam int OUT_W = 2**IN_W;
  localparam int H     = OUT_W / 2;

  always_comb begin
    dout = '0;
    err  = 1'b0;
    case (mode)
      MODE_ONEHOT: begin
        for (int j = 0; j < OUT_W; j++) dout[j] = (int'(din) == j);
      end
      MODE_MIRROR: begin
        // Bit j and bit j+H share a slot; each slot pairs code k with OUT_W-1-k.
        for (int j = 0; j < OUT_W; j++)
          dout[j] = (int'(din) == (j % H)) || (int'(din) == (OUT_W - 1 - (j % H)));
      end
      MODE_THERMO: begin
        for (int j = 0; j < OUT_W; j++) dout[j] = (j <= int'(din));
      end
      default: err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mirror_decoder_skid.sv
// ---------------------------------------------------------------------------
// mirror_decoder_skid : registered code decoder behind a 2-entry skid buffer.
// Optional saturating statistics counters under macro DEC_STAT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mirror_decoder_skid
  import dec_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      din,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [(2**IN_W)-1:0] dout,
  output logic                 out_err,
  output logic [CNT_W-1:0]     stat_acc,
  output logic [CNT_W-1:0]     stat_err
);

  localparam int OUT_W = 2**IN_W;

  skid_state_t      state_q, state_d;
  logic [OUT_W-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_err_q, main_err_d, skid_err_q, skid_err_d;
  logic             in_ready_q;
  logic [OUT_W-1:0] dec_word;
  logic             dec_err;
  logic             accept, pop;

  mirror_decode_core #(.IN_W(IN_W)) u_core (
    .din  (din),
    .mode (mode),
    .dout (dec_word),
    .err  (dec_err)
  );

  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign dout      = out_valid ? main_q : '0;
  assign out_err   = out_valid & main_err_q;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_err_d = main_err_q;
    skid_d     = skid_q;
    skid_err_d = skid_err_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d    = S_ONE;
          main_d     = dec_word;
          main_err_d = dec_err;
        end
      end
      S_ONE: begin
        if (accept && !pop) begin
          state_d    = S_FULL;
          skid_d     = dec_word;
          skid_err_d = dec_err;
        end else if (pop && !accept) begin
          state_d = S_EMPTY;
        end else if (accept && pop) begin
          main_d     = dec_word;
          main_err_d = dec_err;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d    = S_ONE;
          main_d     = skid_q;
          main_err_d = skid_err_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      main_err_q <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      main_err_q <= main_err_d;
      skid_q     <= skid_d;
      skid_err_q <= skid_err_d;
      in_ready_q <= (state_d != S_FULL);
    end
  end

`ifdef DEC_STAT_EN
  logic [CNT_W-1:0] acc_cnt_q, err_cnt_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (accept) begin
      if (acc_cnt_q != '1) acc_cnt_q <= acc_cnt_q + 1'b1;
      if (dec_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign stat_acc = acc_cnt_q;
  assign stat_err = err_cnt_q;
`else
  assign stat_acc = '0;
  assign stat_err = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mirror_decoder_skid.sv
// ---------------------------------------------------------------------------
// tb_mirror_decoder_skid : directed scoreboard bench for mirror_decoder_skid
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mirror_decoder_skid;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  din;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        out_err;
  logic [15:0] stat_acc;
  logic [15:0] stat_err;

  mirror_decoder_skid #(.IN_W(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_err   (out_err),
    .stat_acc  (stat_acc),
    .stat_err  (stat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_acc = 0;
  int          exp_err = 0;
  bit          last_acc;
  int          pops;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // {err, word} expected for IN_W=4
  function automatic logic [16:0] model(input logic [3:0] d, input logic [1:0] m);
    logic [15:0] w;
    int v;
    w = '0;
    v = int'(d);
    case (m)
      2'd0: w[v] = 1'b1;
      2'd1: begin
        if (v < 8) begin
          w[v] = 1'b1; w[v+8] = 1'b1;
        end else begin
          w[15-v] = 1'b1; w[23-v] = 1'b1;
        end
      end
      2'd2: for (int j = 0; j <= v; j++) w[j] = 1'b1;
      default: return {1'b1, 16'h0000};
    endcase
    return {1'b0, w};
  endfunction

  // Called mid low phase with inputs already driven; returns at next negedge.
  task automatic step();
    bit acc, pp;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (sb_q.size() < 2)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (sb_q.size() != 0)});
    if (sb_q.size() != 0) begin
      chk("dout", {16'd0, dout}, {16'd0, sb_q[0][15:0]});
      chk("out_err", {31'd0, out_err}, {31'd0, sb_q[0][16]});
    end else begin
      chk("dout_empty", {16'd0, dout}, 32'd0);
      chk("out_err_empty", {31'd0, out_err}, 32'd0);
    end
`ifdef DEC_STAT_EN
    chk("stat_acc", {16'd0, stat_acc}, exp_acc);
    chk("stat_err", {16'd0, stat_err}, exp_err);
`else
    chk("stat_acc_tied", {16'd0, stat_acc}, 32'd0);
    chk("stat_err_tied", {16'd0, stat_err}, 32'd0);
`endif
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    if (pp && sb_q.size() != 0) begin
      void'(sb_q.pop_front());
      pops++;
    end
    if (acc) begin
      sb_q.push_back(model(din, mode));
      exp_acc++;
      if (mode == 2'd3) exp_err++;
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_timeout", sb_q.size(), 32'd0);
  endtask

  task automatic send1(input logic [1:0] m, input logic [3:0] d);
    in_valid = 1'b1; mode = m; din = d;
    step();
  endtask

  initial begin
    int budget;
    rst_n = 1'b0; in_valid = 1'b0; din = '0; mode = 2'd0; out_ready = 1'b1;
    pops = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    step();

    // Back-to-back mirror codes with a free-flowing consumer
    for (int i = 0; i < 16; i++) send1(2'd1, 4'(i));
    drain();

    // Spot values in each mode
    send1(2'd0, 4'd5);
    chk("onehot5_const", {15'd0, model(4'd5, 2'd0)}, 32'h0000_0020);
    send1(2'd2, 4'd5);
    send1(2'd2, 4'd15);
    send1(2'd2, 4'd0);
    send1(2'd1, 4'd3);
    chk("mirror3_const", {15'd0, model(4'd3, 2'd1)}, 32'h0000_0808);
    send1(2'd1, 4'd12);
    drain();

    // Back-pressure: third word must wait at the producer
    out_ready = 1'b0;
    send1(2'd0, 4'd1);
    send1(2'd0, 4'd2);
    send1(2'd0, 4'd3);
    chk("bp_third_held", {31'd0, last_acc}, 32'd0);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    repeat (3) step();
    out_ready = 1'b1;
    budget = 10;
    last_acc = 1'b0;
    while (!last_acc && budget > 0) begin
      step();
      budget--;
    end
    chk("bp_third_accepted", {31'd0, last_acc}, 32'd1);
    drain();

    // Simultaneous accept and pop while one word is held
    out_ready = 1'b0;
    send1(2'd2, 4'd7);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send1(2'(i % 3), 4'(i + 2));
      chk("ab_accept", {31'd0, last_acc}, 32'd1);
    end
    drain();

    // Reserved mode
    send1(2'd3, 4'd9);
    in_valid = 1'b0;
    chk("rsvd_dout", {16'd0, dout}, 32'd0);
    chk("rsvd_err", {31'd0, out_err}, 32'd1);
    drain();

    // Reset while full, mid-cycle
    out_ready = 1'b0;
    send1(2'd0, 4'd4);
    send1(2'd0, 4'd6);
    in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_dout", {16'd0, dout}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.delete();
    exp_acc = 0;
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send1(2'd1, 4'd8);
    in_valid = 1'b0;
    chk("post_rst_latency", {31'd0, out_valid}, 32'd1);
    chk("post_rst_word", {16'd0, dout}, 32'h0000_8080);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
